instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 34 +++
 rtl/instruction_fetch_if.sv | 44 ++++
 rtl/instruction_fetch_npc.sv | 47 ++++
 rtl/instruction_fetch.sv | 154 +++++++++++++++
 tb/tb_instruction_fetch.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package instruction_fetch_pkg;

  // Reset vector used when the top-level parameter is left at its default.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Fetch controller states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_HALT = 3'd4
  } fetch_state_e;

  // Next-PC source select.
  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  // An address is misaligned when either low bit is set.
  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

  // Sign-extend a 16-bit word offset and turn it into a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of the instruction-memory bus, decode handshake and redirect inputs.
interface instruction_fetch_if;

  // Instruction memory bus
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // Decode handshake
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] pc;

  // Redirect operands, sampled only when decode accepts an instruction
  logic        branch_taken;
  logic        jump;
  logic        jr;
  logic [15:0] imm16;
  logic [25:0] target;
  logic [31:0] jr_addr;

  // Out-of-flow redirect and status
  logic        flush;
  logic [31:0] flush_pc;
  logic        addr_err;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, inst_valid, instruction, pc, addr_err,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready,
           branch_taken, jump, jr, imm16, target, jr_addr, flush, flush_pc
  );

  // Environment side (memory, decode, exception logic)
  modport slave (
    input  imem_req, imem_addr, inst_valid, instruction, pc, addr_err,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready,
           branch_taken, jump, jr, imm16, target, jr_addr, flush, flush_pc
  );

endinterface

// File: rtl/instruction_fetch_npc.sv
// Combinational next-PC selector: jr > jump > branch > sequential.
module instruction_fetch_npc
  import instruction_fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_branch_taken,
  input  logic        i_jump,
  input  logic        i_jr,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_target,
  input  logic [31:0] i_jr_addr,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_pc_plus4;
  npc_sel_e    w_sel;

  // Sequential address; wraps naturally at the top of the address space.
  assign w_pc_plus4 = i_pc + 32'd4;

  // Priority encode the redirect requests into a source select.
  always_comb begin
    w_sel = NPC_SEQ;
    if (i_jr) begin
      w_sel = NPC_JR;
    end else if (i_jump) begin
      w_sel = NPC_J;
    end else if (i_branch_taken) begin
      w_sel = NPC_BR;
    end else begin
      w_sel = NPC_SEQ;
    end
  end

  // Build the next PC for the selected source.
  always_comb begin
    o_next_pc = w_pc_plus4;
    case (w_sel)
      NPC_JR:  o_next_pc = i_jr_addr;
      NPC_J:   o_next_pc = {w_pc_plus4[31:28], i_target, 2'b00};
      NPC_BR:  o_next_pc = w_pc_plus4 + branch_offset(i_imm16);
      NPC_SEQ: o_next_pc = w_pc_plus4;
      default: o_next_pc = w_pc_plus4;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: one outstanding memory request, holds the fetched
// word for decode, redirects on handshake or flush, halts on a misaligned PC.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          PC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  instruction_fetch_if.master  io_fetch
);

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [31:0]         w_npc;
  logic [31:0]         r_instr;
  logic [31:0]         w_instr_nxt;
  logic                r_imem_req;
  logic                w_imem_req_nxt;
  logic                r_inst_valid;
  logic                w_inst_valid_nxt;
  logic                r_addr_err;
  logic                w_addr_err_nxt;
  logic                r_drop;
  logic                w_drop_nxt;
  logic                w_handshake;
  logic                w_rsp;
  logic                w_outstanding;
  logic                w_flush_bad;
  logic                w_npc_bad;

  instruction_fetch_npc u_npc (
    .i_pc           (r_pc),
    .i_branch_taken (io_fetch.branch_taken),
    .i_jump         (io_fetch.jump),
    .i_jr           (io_fetch.jr),
    .i_imm16        (io_fetch.imm16),
    .i_target       (io_fetch.target),
    .i_jr_addr      (io_fetch.jr_addr),
    .o_next_pc      (w_npc)
  );

  // Decode accepts the held instruction this cycle.
  assign w_handshake   = (r_state == ST_HOLD) && io_fetch.inst_ready;
  // Memory response that belongs to us (responses outside WAIT are ignored).
  assign w_rsp         = (r_state == ST_WAIT) && io_fetch.imem_rvalid;
  // A response will still arrive after this cycle: waiting without data yet,
  // or a request being granted right now.
  assign w_outstanding = ((r_state == ST_WAIT) && !io_fetch.imem_rvalid) ||
                         ((r_state == ST_REQ) && io_fetch.imem_gnt);
  assign w_flush_bad   = addr_misaligned(io_fetch.flush_pc[1:0]);
  assign w_npc_bad     = addr_misaligned(w_npc[1:0]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides everything including a handshake.
  always_comb begin
    w_state_nxt = r_state;
    if (io_fetch.flush) begin
      if (w_flush_bad) begin
        w_state_nxt = ST_HALT;
      end else if (w_outstanding) begin
        w_state_nxt = ST_WAIT;
      end else begin
        w_state_nxt = ST_REQ;
      end
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_REQ;
        ST_REQ:  w_state_nxt = io_fetch.imem_gnt ? ST_WAIT : ST_REQ;
        ST_WAIT: begin
          if (io_fetch.imem_rvalid) begin
            w_state_nxt = r_drop ? ST_REQ : ST_HOLD;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (w_handshake) begin
            w_state_nxt = w_npc_bad ? ST_HALT : ST_REQ;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HALT: w_state_nxt = ST_HALT;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode from the next state so the outputs can be registered.
  always_comb begin
    w_imem_req_nxt   = (w_state_nxt == ST_REQ);
    w_inst_valid_nxt = (w_state_nxt == ST_HOLD);
  end

  // Next values for PC, instruction, error flag and the drop-response flag.
  always_comb begin
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_addr_err_nxt = r_addr_err;
    w_drop_nxt     = r_drop;
    if (io_fetch.flush) begin
      w_pc_nxt       = io_fetch.flush_pc;
      w_addr_err_nxt = w_flush_bad;
      w_drop_nxt     = !w_flush_bad && w_outstanding;
    end else if (w_handshake) begin
      w_pc_nxt       = w_npc;
      w_addr_err_nxt = r_addr_err || w_npc_bad;
    end else if (w_rsp) begin
      w_drop_nxt  = 1'b0;
      w_instr_nxt = r_drop ? r_instr : io_fetch.imem_rdata;
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_instr      <= 32'h0000_0000;
      r_addr_err   <= 1'b0;
      r_drop       <= 1'b0;
      r_imem_req   <= 1'b0;
      r_inst_valid <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_instr      <= w_instr_nxt;
      r_addr_err   <= w_addr_err_nxt;
      r_drop       <= w_drop_nxt;
      r_imem_req   <= w_imem_req_nxt;
      r_inst_valid <= w_inst_valid_nxt;
    end
  end

  assign io_fetch.imem_req    = r_imem_req;
  assign io_fetch.imem_addr   = r_pc;
  assign io_fetch.inst_valid  = r_inst_valid;
  assign io_fetch.instruction = r_instr;
  assign io_fetch.pc          = r_pc;
  assign io_fetch.addr_err    = r_addr_err;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small instruction memory model.
module tb_instruction_fetch;

  localparam logic [31:0] MAGIC = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_miscmp = 0;

  instruction_fetch_if bus();

  instruction_fetch #(.RESET_PC(32'h0000_3000), .PC_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .io_fetch (bus)
  );

  always #5 clk = ~clk;

  // Memory model state
  logic        gnt_hold = 1'b0;
  int          lat = 0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;
  int          cyc = 0;
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];

  assign bus.imem_gnt    = bus.imem_req & ~gnt_hold;
  assign bus.imem_rvalid = m_rvalid;
  assign bus.imem_rdata  = m_rdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_2000) ? 32'hDEAD_BEEF : (a ^ MAGIC);
  endfunction

  // Memory: answers lat cycles after the zero-latency slot; not reset by rst.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    m_rvalid <= 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        m_rvalid <= 1'b1;
        m_rdata  <= mem_word(paddr);
        pend     <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (bus.imem_req && bus.imem_gnt) begin
      acc_addr.push_back(bus.imem_addr);
      acc_cyc.push_back(cyc);
      if (lat == 0) begin
        m_rvalid <= 1'b1;
        m_rdata  <= mem_word(bus.imem_addr);
      end else begin
        pend  <= 1'b1;
        cnt   <= lat - 1;
        paddr <= bus.imem_addr;
      end
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int i;
    i = 0;
    while (!bus.inst_valid && i < 30) begin
      step();
      i++;
    end
    check_value(tag, {31'd0, bus.inst_valid}, 32'd1);
  endtask

  task automatic flush_to(input logic [31:0] fpc);
    bus.flush    = 1'b1;
    bus.flush_pc = fpc;
    step();
    bus.flush    = 1'b0;
  endtask

  task automatic goto_hold(input logic [31:0] fpc);
    flush_to(fpc);
    wait_valid("goto_valid");
  endtask

  task automatic handshake(input logic br, input logic j, input logic jr,
                           input logic [15:0] imm, input logic [25:0] tgt,
                           input logic [31:0] jra);
    bus.branch_taken = br;
    bus.jump         = j;
    bus.jr           = jr;
    bus.imm16        = imm;
    bus.target       = tgt;
    bus.jr_addr      = jra;
    bus.inst_ready   = 1'b1;
    step();
    bus.inst_ready   = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jump         = 1'b0;
    bus.jr           = 1'b0;
    bus.imm16        = 16'h0;
    bus.target       = 26'h0;
    bus.jr_addr      = 32'h0;
  endtask

  initial begin
    int          n;
    int          i;
    logic        saw_valid;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    bus.inst_ready   = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jump         = 1'b0;
    bus.jr           = 1'b0;
    bus.imm16        = 16'h0;
    bus.target       = 26'h0;
    bus.jr_addr      = 32'h0;
    bus.flush        = 1'b0;
    bus.flush_pc     = 32'h0;

    // Reset state
    step();
    step();
    check_value("rst_pc", bus.pc, 32'h0000_3000);
    check_value("rst_instr", bus.instruction, 32'h0);
    check_value("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check_value("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check_value("rst_err", {31'd0, bus.addr_err}, 32'd0);

    // Streaming with zero-latency memory, decode always ready
    acc_addr.delete();
    acc_cyc.delete();
    bus.inst_ready = 1'b1;
    rst = 1'b0;
    step();
    check_value("idle_to_req", {31'd0, bus.imem_req}, 32'd1);
    check_value("first_addr", bus.imem_addr, 32'h0000_3000);
    saw_valid = 1'b0;
    i = 0;
    while (acc_addr.size() < 3 && i < 20) begin
      step();
      if (bus.inst_valid && !saw_valid) begin
        saw_valid = 1'b1;
        check_value("first_instr", bus.instruction, 32'h0000_3000 ^ MAGIC);
      end
      i++;
    end
    bus.inst_ready = 1'b0;
    check_value("stream_cnt", acc_addr.size(), 32'd3);
    if (acc_addr.size() >= 3) begin
      check_value("stream_a0", acc_addr[0], 32'h0000_3000);
      check_value("stream_a1", acc_addr[1], 32'h0000_3004);
      check_value("stream_a2", acc_addr[2], 32'h0000_3008);
      check_value("stream_gap1", acc_cyc[1] - acc_cyc[0], 32'd3);
      check_value("stream_gap2", acc_cyc[2] - acc_cyc[1], 32'd3);
    end

    // Stall in HOLD for 5 cycles
    goto_hold(32'h0000_3010);
    hold_pc    = bus.pc;
    hold_instr = bus.instruction;
    check_value("hold_pc0", hold_pc, 32'h0000_3010);
    check_value("hold_instr0", hold_instr, 32'h0000_3010 ^ MAGIC);
    for (int k = 0; k < 5; k++) begin
      step();
      check_value("hold_noreq", {31'd0, bus.imem_req}, 32'd0);
    end
    check_value("hold_pc", bus.pc, hold_pc);
    check_value("hold_instr", bus.instruction, hold_instr);

    // Backward branch
    handshake(1'b1, 1'b0, 1'b0, 16'hFFFC, 26'h0, 32'h0);
    check_value("br_req", {31'd0, bus.imem_req}, 32'd1);
    check_value("br_addr", bus.imem_addr, 32'h0000_3004);

    // Jump
    goto_hold(32'h0000_3010);
    handshake(1'b0, 1'b1, 1'b0, 16'h0, 26'h000_0C04, 32'h0);
    check_value("j_addr", bus.imem_addr, 32'h0000_3010);

    // jr wins over jump
    goto_hold(32'h0000_3010);
    handshake(1'b0, 1'b1, 1'b1, 16'h0, 26'h000_0C04, 32'h0000_4000);
    check_value("jr_addr", bus.imem_addr, 32'h0000_4000);

    // Redirect inputs outside the handshake are ignored
    goto_hold(32'h0000_3010);
    bus.jr = 1'b1;
    bus.branch_taken = 1'b1;
    bus.jr_addr = 32'h0000_5000;
    step();
    bus.jr = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jr_addr = 32'h0;
    step();
    handshake(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    check_value("ignore_redir", bus.imem_addr, 32'h0000_3014);

    // Sequential wrap at the top of the address space
    goto_hold(32'hFFFF_FFFC);
    handshake(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    check_value("wrap_addr", bus.imem_addr, 32'h0000_0000);
    wait_valid("wrap_valid");
    check_value("wrap_instr", bus.instruction, MAGIC);

    // Flush while a response is outstanding: response is discarded
    lat = 2;
    flush_to(32'h0000_2000);
    n = acc_addr.size();
    i = 0;
    while (acc_addr.size() == n && i < 10) begin
      step();
      i++;
    end
    check_value("drop_accept", acc_addr.size(), n + 1);
    flush_to(32'h0000_8000);
    saw_valid = 1'b0;
    i = 0;
    while (!bus.imem_req && i < 10) begin
      step();
      if (bus.inst_valid) saw_valid = 1'b1;
      i++;
    end
    check_value("drop_novalid", {31'd0, saw_valid}, 32'd0);
    check_value("drop_addr", bus.imem_addr, 32'h0000_8000);
    wait_valid("drop_valid");
    check_value("drop_instr", bus.instruction, 32'h0000_8000 ^ MAGIC);

    // Misaligned jr target halts fetch
    lat = 0;
    goto_hold(32'h0000_3010);
    handshake(1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h0000_3002);
    check_value("halt_err", {31'd0, bus.addr_err}, 32'd1);
    check_value("halt_req", {31'd0, bus.imem_req}, 32'd0);
    check_value("halt_valid", {31'd0, bus.inst_valid}, 32'd0);
    check_value("halt_pc", bus.pc, 32'h0000_3002);
    n = acc_addr.size();
    repeat (5) step();
    check_value("halt_noacc", acc_addr.size(), n);
    flush_to(32'h0000_3001);
    check_value("halt_badflush_err", {31'd0, bus.addr_err}, 32'd1);
    check_value("halt_badflush_req", {31'd0, bus.imem_req}, 32'd0);
    flush_to(32'h0000_3000);
    check_value("restart_err", {31'd0, bus.addr_err}, 32'd0);
    check_value("restart_addr", bus.imem_addr, 32'h0000_3000);
    wait_valid("restart_valid");

    // Asynchronous reset while a response is outstanding
    lat = 2;
    flush_to(32'h0000_6000);
    n = acc_addr.size();
    i = 0;
    while (acc_addr.size() == n && i < 10) begin
      step();
      i++;
    end
    #2;
    rst = 1'b1;
    #1;
    check_value("arst_pc", bus.pc, 32'h0000_3000);
    check_value("arst_req", {31'd0, bus.imem_req}, 32'd0);
    step();
    rst = 1'b0;
    wait_valid("arst_valid");
    check_value("arst_instr", bus.instruction, 32'h0000_3000 ^ MAGIC);
    check_value("arst_pc2", bus.pc, 32'h0000_3000);

    // Grant withheld: request and address stay put
    gnt_hold = 1'b1;
    flush_to(32'h0000_7000);
    n = acc_addr.size();
    for (int k = 0; k < 3; k++) begin
      step();
      check_value("stall_req", {31'd0, bus.imem_req}, 32'd1);
      check_value("stall_addr", bus.imem_addr, 32'h0000_7000);
    end
    check_value("stall_noacc", acc_addr.size(), n);
    gnt_hold = 1'b0;
    wait_valid("stall_valid");
    check_value("stall_instr", bus.instruction, 32'h0000_7000 ^ MAGIC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
